// File: rtl/mw_add_pkg.sv
// Shared types for the multi-word add sequencer: FSM state encoding and chunk-index sizing.
package mw_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // A single-chunk build still needs a 1-bit index register.
    function automatic int idx_width(input int n);
        if (n <= 1) return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/mw_add_seq_if.sv
// Operand/result handshake bundle for mw_add_seq; op_sub exists only when MW_ADD_SUB_EN is defined.
interface mw_add_seq_if #(
    parameter int W = 4,
    parameter int N = 4
);
    localparam int D = W * N;

    logic         in_valid;
    logic         in_ready;
    logic [D-1:0] a;
    logic [D-1:0] b;
    logic         c_in;
`ifdef MW_ADD_SUB_EN
    logic         op_sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [D-1:0] sum;
    logic         c_out;
    logic         busy;

    modport master (
        output in_valid, a, b, c_in,
`ifdef MW_ADD_SUB_EN
        output op_sub,
`endif
        output out_ready,
        input  in_ready, out_valid, sum, c_out, busy
    );

    modport slave (
        input  in_valid, a, b, c_in,
`ifdef MW_ADD_SUB_EN
        input  op_sub,
`endif
        input  out_ready,
        output in_ready, out_valid, sum, c_out, busy
    );

endinterface

// File: rtl/fa_n.sv
// W-bit ripple-carry adder shared by the sequencer across all chunks.
module fa_n #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic carry;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        s     = '0;
        carry = ci;
        for (int i = 0; i < W; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        co = carry;
    end

endmodule

// File: rtl/mw_add_seq.sv
// Multi-word add sequencer: one W-bit fa_n reused for N cycles, LSB chunk first.
// Define MW_ADD_SUB_EN to add the op_sub port (a - b via inverted b and carry-in of 1).
module mw_add_seq
    import mw_add_pkg::*;
#(
    parameter int W = 4,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    mw_add_seq_if.slave  bus
);

    localparam int D  = W * N;
    localparam int IW = idx_width(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q,   idx_d;
    logic          carry_q, carry_d;
    logic [D-1:0]  a_q,     a_d;
    logic [D-1:0]  b_q,     b_d;
    logic [D-1:0]  sum_q,   sum_d;
    logic          c_out_q, c_out_d;
    logic          sub_q,   sub_d;
    logic          sub_in;

    logic [W-1:0]  a_chunk, b_chunk, fa_s;
    logic          fa_co;

`ifdef MW_ADD_SUB_EN
    assign sub_in = bus.op_sub;
`else
    assign sub_in = 1'b0;
`endif

    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IW'(i)) begin
                a_chunk = a_q[i*W +: W];
                b_chunk = b_q[i*W +: W];
            end
        end
        // Subtraction is a + ~b + 1; the +1 enters through the initial carry.
        b_chunk = b_chunk ^ {W{sub_q}};
    end

    fa_n #(.W(W)) u_fa (
        .a  (a_chunk),
        .b  (b_chunk),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        sub_d   = sub_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sub_d   = sub_in;
                    carry_d = sub_in ? 1'b1 : bus.c_in;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < N; i++) begin
                    if (idx_q == IW'(i)) sum_d[i*W +: W] = fa_s;
                end
                carry_d = fa_co;
                if (idx_q == LAST_IDX) begin
                    c_out_d = fa_co;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            sub_q   <= sub_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == RUN) || (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;

endmodule

// File: tb/tb_mw_add_seq.sv
// Directed bench for mw_add_seq: a W=4/N=4 instance plus a W=8/N=1 instance; subtract vectors under MW_ADD_SUB_EN.
module tb_mw_add_seq;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    mw_add_seq_if #(.W(4), .N(4)) bus ();
    mw_add_seq_if #(.W(8), .N(1)) bus1 ();

    mw_add_seq #(.W(4), .N(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    mw_add_seq #(.W(8), .N(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
        bus.a        = a;
        bus.b        = b;
        bus.c_in     = cin;
`ifdef MW_ADD_SUB_EN
        bus.op_sub   = sub;
`else
        if (sub) $display("[TB] op_sub requested without MW_ADD_SUB_EN");
`endif
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid, and whether busy stayed high.
    task automatic wait_done(output int lat, output bit busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        while (!bus.out_valid && lat < 20) begin
            if (!bus.busy) busy_ok = 1'b0;
            tick();
            lat++;
        end
        if (!bus.busy) busy_ok = 1'b0;
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.sum !== 16'h0 || bus.c_out !== 1'b0 || bus.out_valid !== 1'b0 ||
            bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: sum=%h c_out=%b ov=%b ir=%b busy=%b, want 0000 0 0 1 0",
                     bus.sum, bus.c_out, bus.out_valid, bus.in_ready, bus.busy);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic run_add(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic sub,
                           input logic [15:0] exp_sum, input logic exp_cout);
        int lat;
        bit busy_ok;
        start_op(a, b, cin, sub);
        wait_done(lat, busy_ok);
        tests++;
        if (lat !== 4) begin
            fails++;
            $display("FAIL %s_latency: got %0d cycles, want 4", name, lat);
        end
        tests++;
        if (!busy_ok) begin
            fails++;
            $display("FAIL %s_busy: busy dropped during operation, want high throughout", name);
        end
        tests++;
        if (bus.sum !== exp_sum || bus.c_out !== exp_cout) begin
            fails++;
            $display("FAIL %s_result: sum=%h c_out=%b, want %h %b", name, bus.sum, bus.c_out, exp_sum, exp_cout);
        end
        release_result();
        tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_return_idle: ov=%b ir=%b busy=%b, want 0 1 0",
                     name, bus.out_valid, bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_add();
        run_add("add_basic",  16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0);
        run_add("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
        run_add("add_cin",    16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0);
    endtask

    task automatic test_backpressure();
        int lat;
        bit busy_ok;
        start_op(16'h00FF, 16'h0F01, 1'b0, 1'b0);
        wait_done(lat, busy_ok);
        // New operand presented while DONE must be ignored until the block is back in IDLE.
        bus.a        = 16'h8000;
        bus.b        = 16'h8000;
        bus.c_in     = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.sum !== 16'h1000 || bus.c_out !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold_%0d: ov=%b ir=%b sum=%h c_out=%b, want 1 0 1000 0",
                         i, bus.out_valid, bus.in_ready, bus.sum, bus.c_out);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL bp_idle: ir=%b ov=%b busy=%b, want 1 0 0", bus.in_ready, bus.out_valid, bus.busy);
        end
        tick();
        bus.in_valid = 1'b0;
        tests++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_accept: busy=%b ir=%b, want 1 0", bus.busy, bus.in_ready);
        end
        wait_done(lat, busy_ok);
        tests++;
        if (lat !== 4 || bus.sum !== 16'h0000 || bus.c_out !== 1'b1) begin
            fails++;
            $display("FAIL bp_next_result: lat=%0d sum=%h c_out=%b, want 4 0000 1", lat, bus.sum, bus.c_out);
        end
        release_result();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        bit busy_ok;
        start_op(16'hAAAA, 16'h5555, 1'b1, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.sum !== 16'h0 || bus.c_out !== 1'b0 || bus.out_valid !== 1'b0 ||
            bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL midrun_reset: sum=%h c_out=%b ov=%b ir=%b busy=%b, want 0000 0 0 1 0",
                     bus.sum, bus.c_out, bus.out_valid, bus.in_ready, bus.busy);
        end
        tick();
        rst_n = 1'b1;
        tick();
        start_op(16'h0001, 16'h0002, 1'b0, 1'b0);
        wait_done(lat, busy_ok);
        tests++;
        if (lat !== 4 || bus.sum !== 16'h0003 || bus.c_out !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_add: lat=%0d sum=%h c_out=%b, want 4 0003 0", lat, bus.sum, bus.c_out);
        end
        release_result();
    endtask

    task automatic test_single_chunk();
        int lat;
        bus1.a        = 8'hF0;
        bus1.b        = 8'h20;
        bus1.c_in     = 1'b0;
        bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        lat = 0;
        while (!bus1.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        tests++;
        if (lat !== 1) begin
            fails++;
            $display("FAIL n1_latency: got %0d cycles, want 1", lat);
        end
        tests++;
        if (bus1.sum !== 8'h10 || bus1.c_out !== 1'b1) begin
            fails++;
            $display("FAIL n1_result: sum=%h c_out=%b, want 10 1", bus1.sum, bus1.c_out);
        end
        bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;
    endtask

`ifdef MW_ADD_SUB_EN
    task automatic test_sub();
        run_add("sub_borrow",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
        run_add("sub_noborrow", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);
        run_add("sub_off_add",  16'h0007, 16'h0005, 1'b1, 1'b0, 16'h000D, 1'b0);
    endtask
`endif

    initial begin
        tests          = 0;
        fails          = 0;
        bus.in_valid   = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        bus.c_in       = 1'b0;
        bus.out_ready  = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.a         = '0;
        bus1.b         = '0;
        bus1.c_in      = 1'b0;
        bus1.out_ready = 1'b0;
`ifdef MW_ADD_SUB_EN
        bus.op_sub     = 1'b0;
        bus1.op_sub    = 1'b0;
`endif
        test_reset();
        test_add();
        test_backpressure();
        test_reset_mid_run();
        test_single_chunk();
`ifdef MW_ADD_SUB_EN
        test_sub();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
